inverse_conjugation_engine: RTL and testbench
=============================================

Name: inverse_conjugation_engine

Overview:
- Undoes a recorded Clifford circuit on a stabilizer tableau.
- Gates (H, S, CNOT) are pushed into a LIFO as they are applied in the forward direction.
- On start, gates are popped in reverse order, one per cycle, and the inverse conjugation (H, S-dagger, CNOT) is applied to every row of a held tableau.
- Sits beside the forward literal-update path in the Heisenberg emulator; used for uncompute and for verifying round-trip tableaux.

Parameters:
- num_qubit, 4, qubits (tableau columns) and tableau rows.
- DEPTH, 16, LIFO gate capacity.
- QW, $clog2(num_qubit), qubit index width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- load  input  1  capture tableau_in/phase_in; honoured in IDLE only.
- tableau_in  input  2*num_qubit*num_qubit  row r, column q literal at bits [2*(r*num_qubit+q)+:2].
- phase_in  input  num_qubit  per-row sign (1 = negative).
- gate_valid  input  1  gate push request.
- gate_ready  output  1  push accepted when valid&ready.
- gate_type  input  2  0 H, 1 S, 2 CNOT, 3 identity.
- gate_q1  input  QW  target for H/S; control for CNOT.
- gate_q2  input  QW  CNOT target; ignored otherwise.
- start  input  1  begin reverse replay; honoured in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at replay completion.
- gate_count  output  $clog2(DEPTH+1)  LIFO occupancy.
- err  output  1  sticky illegal-gate flag.
- tableau_out  output  2*num_qubit*num_qubit  current tableau, registered.
- phase_out  output  num_qubit  current signs, registered.

Behaviour:
- Literal encoding is 0 I, 1 Z, 2 X, 3 Y. Bit1 is x, bit0 is z.
- Reset (synchronous) values: tableau all I, phases 0, gate_count 0, LIFO empty, state IDLE, busy 0, done 0, err 0.
- gate_ready = (state==IDLE) && (gate_count<DEPTH). It is 1 after reset.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - load overwrites tableau and phase on the next edge.
  - A push writes to the top of the LIFO and increments gate_count.
  - load and push in the same cycle are both honoured.
  - On start: if gate_count>0, go to RUN; else go to DONE. start takes priority over load and push in the same cycle; both are dropped.
- RUN:
  - Each cycle pops the top entry, applies it to all rows in parallel, and decrements gate_count.
  - When gate_count goes from 1 to 0, go to DONE.
  - load, start and pushes are ignored.
- DONE: done=1 for exactly one cycle, then IDLE. The tableau holds its final value.
- Latency: N gates give done N+1 cycles after the start edge. N=0 gives done 1 cycle after the start edge.
- Per-row inverse maps for column q:
  - H: Z→X, X→Z, Y→Y with phase toggle, I→I.
  - S-dagger: Z→Z, X→Y with phase toggle, Y→X, I→I.
  - CNOT(c,t):
    - x_t' = x_t ^ x_c.
    - z_c' = z_c ^ z_t.
    - x_c and z_t are unchanged.
    - Phase toggles when x_c & z_t & ~(x_t ^ z_c).
- Illegal gates are applied as no-ops and set err. Illegal means any index ≥ num_qubit, or CNOT with q1==q2.
- Type 3 is a no-op and does not set err.
- err clears only on rst.
- Reset mid-RUN returns to IDLE, empties the LIFO and clears the tableau. No done is issued.

Test Plan:
- num_qubit=2. Load row0=(X,I) with phase 0. Push H q0, then S q0. Start → RUN 2 cycles, done on cycle 3; row0=(Y,I), phase0=0, because S-dagger gives −Y and then H gives +Y.
- Load row0=(X,Z) with phase 0. Push CNOT(0,1). Start → row0=(Y,Y), phase0=1. Load row1=(Y,Y) with phase 0 and replay the same CNOT → (X,Z), phase 1.
- DEPTH=4: push 4 gates → gate_count=4 and gate_ready=0; a 5th valid is not accepted. Start then pushes give gate_ready=0 during RUN.
- Start with an empty LIFO → done exactly 1 cycle later, busy never high, tableau unchanged.
- Push CNOT(1,1), then H q0. Load row0=(Z,I). Start → err=1; row0=(X,I).
- Push 3 gates, start, assert rst in the 2nd RUN cycle → next cycle: IDLE, gate_count=0, tableau all I, done never pulses, gate_ready=1.

Source files
------------

// File: rtl/inverse_conjugation_engine.sv
// Reverse-replay engine: recorded H/S/CNOT gates are popped from a LIFO and their
// inverse conjugation is applied to every row of a held stabilizer tableau.
module inverse_conjugation_engine #(
   parameter int num_qubit = 4,
   parameter int DEPTH     = 16,
   parameter int QW        = $clog2(num_qubit)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load,
   input  logic [2*num_qubit*num_qubit-1:0] tableau_in,
   input  logic [num_qubit-1:0]             phase_in,
   input  logic                             gate_valid,
   output logic                             gate_ready,
   input  logic [1:0]                       gate_type,
   input  logic [QW-1:0]                    gate_q1,
   input  logic [QW-1:0]                    gate_q2,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic [$clog2(DEPTH+1)-1:0]       gate_count,
   output logic                             err,
   output logic [2*num_qubit*num_qubit-1:0] tableau_out,
   output logic [num_qubit-1:0]             phase_out
);
   localparam int N  = num_qubit;
   localparam int RW = 2 * N;
   localparam int TW = RW * N;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] G_H    = 2'd0;
   localparam logic [1:0] G_S    = 2'd1;
   localparam logic [1:0] G_CNOT = 2'd2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [1:0]    kind;
      logic [QW-1:0] q1;
      logic [QW-1:0] q2;
   } gate_t;

   state_t          state;
   gate_t           lifo [DEPTH];
   gate_t           top_gate;
   logic [AW-1:0]   top_idx;
   logic            top_illegal;
   logic            push_fire;
   logic [TW-1:0]   tab_next;
   logic [N-1:0]    phase_next;
   logic [RW:0]     row_res;

   // Inverse conjugation of one row; returns {new_sign, new_row}.
   // Column selects are unrolled against the gate indices so no runtime bit index is needed.
   function automatic logic [RW:0] invert_row(input logic [RW-1:0] row,
                                              input logic          sign,
                                              input gate_t         g);
      logic [RW-1:0] r;
      logic          s;
      logic          xc, zc, xt, zt;
      int            a, b;
      r  = row;
      a  = int'(g.q1);
      b  = int'(g.q2);
      xc = 1'b0;
      zc = 1'b0;
      xt = 1'b0;
      zt = 1'b0;
      for (int q = 0; q < N; q++) begin
         if (q == a) begin
            xc = row[2*q+1];
            zc = row[2*q];
         end
         if (q == b) begin
            xt = row[2*q+1];
            zt = row[2*q];
         end
      end
      for (int q = 0; q < N; q++) begin
         case (g.kind)
            G_H: begin
               if (q == a) begin
                  r[2*q+1] = zc;
                  r[2*q]   = xc;
               end
            end
            G_S: begin
               if (q == a) r[2*q] = zc ^ xc;
            end
            G_CNOT: begin
               if (q == b) r[2*q+1] = xt ^ xc;
               if (q == a) r[2*q]   = zc ^ zt;
            end
            default: ;
         endcase
      end
      case (g.kind)
         G_H:     s = sign ^ (xc & zc);
         G_S:     s = sign ^ (xc & ~zc);
         G_CNOT:  s = sign ^ (xc & zt & ~(xt ^ zc));
         default: s = sign;
      endcase
      return {s, r};
   endfunction

   assign gate_ready = (state == IDLE) && (gate_count < CW'(DEPTH));
   assign push_fire  = (state == IDLE) && !start && gate_valid && gate_ready;
   assign top_idx    = AW'(gate_count - CW'(1));
   assign top_gate   = lifo[top_idx];

   // Out-of-range qubits and self-targeted CNOTs are refused; identity is always legal.
   always_comb begin
      top_illegal = 1'b0;
      case (top_gate.kind)
         G_H, G_S: top_illegal = (int'(top_gate.q1) >= N);
         G_CNOT:   top_illegal = (int'(top_gate.q1) >= N) || (int'(top_gate.q2) >= N) ||
                                 (top_gate.q1 == top_gate.q2);
         default:  top_illegal = 1'b0;
      endcase
   end

   // All rows are updated in parallel from the gate at the top of the LIFO.
   always_comb begin
      tab_next   = tableau_out;
      phase_next = phase_out;
      row_res    = '0;
      for (int r = 0; r < N; r++) begin
         row_res = invert_row(tableau_out[r*RW +: RW], phase_out[r], top_gate);
         if (!top_illegal) begin
            tab_next[r*RW +: RW] = row_res[RW-1:0];
            phase_next[r]        = row_res[RW];
         end
      end
   end

   // Gate storage; occupancy lives in gate_count, so entries need no reset.
   always_ff @(posedge clk) begin
      if (!rst && push_fire) begin
         lifo[AW'(gate_count)] <= '{kind: gate_type, q1: gate_q1, q2: gate_q2};
      end
   end

   // Control FSM; start in IDLE wins over a simultaneous load or push.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         gate_count  <= '0;
         err         <= 1'b0;
         tableau_out <= '0;
         phase_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (gate_count != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  if (load) begin
                     tableau_out <= tableau_in;
                     phase_out   <= phase_in;
                  end
                  if (push_fire) gate_count <= gate_count + CW'(1);
               end
            end
            RUN: begin
               tableau_out <= tab_next;
               phase_out   <= phase_next;
               gate_count  <= gate_count - CW'(1);
               if (top_illegal) err <= 1'b1;
               if (gate_count == CW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inverse_conjugation_engine.sv
// Scoreboard bench for inverse_conjugation_engine: a Pauli-letter model predicts each
// replay, and a monitor compares whenever done pulses.
module tb_inverse_conjugation_engine;
   localparam int NQ    = 3;
   localparam int DEPTH = 4;
   localparam int QW    = $clog2(NQ);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int RW    = 2 * NQ;
   localparam int TW    = RW * NQ;

   logic            clk = 1'b0;
   logic            rst, load, gate_valid, start;
   logic [TW-1:0]   tableau_in;
   logic [NQ-1:0]   phase_in;
   logic [1:0]      gate_type;
   logic [QW-1:0]   gate_q1, gate_q2;
   logic            gate_ready, busy, done, err;
   logic [CW-1:0]   gate_count;
   logic [TW-1:0]   tableau_out;
   logic [NQ-1:0]   phase_out;

   typedef struct {
      logic [1:0] kind;
      int         q1;
      int         q2;
   } gate_rec_t;

   typedef struct {
      logic [TW-1:0] tab;
      logic [NQ-1:0] ph;
      logic          er;
      int            done_cyc;
   } exp_t;

   byte       m_tab  [NQ][NQ];
   bit        m_sign [NQ];
   bit        m_err;
   gate_rec_t m_lifo [$];
   exp_t      sb     [$];
   exp_t      mon_e;
   int        cyc = 0;
   int        n_checks = 0;
   int        n_pass = 0;

   inverse_conjugation_engine #(.num_qubit(NQ), .DEPTH(DEPTH), .QW(QW)) dut (
      .clk(clk), .rst(rst), .load(load), .tableau_in(tableau_in), .phase_in(phase_in),
      .gate_valid(gate_valid), .gate_ready(gate_ready), .gate_type(gate_type),
      .gate_q1(gate_q1), .gate_q2(gate_q2), .start(start), .busy(busy), .done(done),
      .gate_count(gate_count), .err(err), .tableau_out(tableau_out), .phase_out(phase_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Pauli letters <-> two-bit literal codes.
   function automatic logic [1:0] enc(input byte p);
      case (p)
         "Z":     return 2'd1;
         "X":     return 2'd2;
         "Y":     return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic byte dec(input logic [1:0] c);
      case (c)
         2'd1:    return "Z";
         2'd2:    return "X";
         2'd3:    return "Y";
         default: return "I";
      endcase
   endfunction

   // Single-qubit inverse conjugation tables: {sign_flip, letter}.
   function automatic logic [8:0] h_inv(input byte p);
      case (p)
         "X":     return {1'b0, 8'("Z")};
         "Z":     return {1'b0, 8'("X")};
         "Y":     return {1'b1, 8'("Y")};
         default: return {1'b0, 8'("I")};
      endcase
   endfunction

   function automatic logic [8:0] sdg_inv(input byte p);
      case (p)
         "X":     return {1'b1, 8'("Y")};
         "Y":     return {1'b0, 8'("X")};
         "Z":     return {1'b0, 8'("Z")};
         default: return {1'b0, 8'("I")};
      endcase
   endfunction

   // CNOT conjugation of (control, target) letter pairs: {sign_flip, control', target'}.
   function automatic logic [16:0] cnot_inv(input byte c, input byte t);
      logic [15:0] key;
      key = {c, t};
      case (key)
         "IZ":    return {1'b0, 16'("ZZ")};
         "IY":    return {1'b0, 16'("ZY")};
         "XI":    return {1'b0, 16'("XX")};
         "XX":    return {1'b0, 16'("XI")};
         "XZ":    return {1'b1, 16'("YY")};
         "XY":    return {1'b0, 16'("YZ")};
         "ZZ":    return {1'b0, 16'("IZ")};
         "ZY":    return {1'b0, 16'("IY")};
         "YI":    return {1'b0, 16'("YX")};
         "YX":    return {1'b0, 16'("YI")};
         "YZ":    return {1'b0, 16'("XY")};
         "YY":    return {1'b1, 16'("XZ")};
         default: return {1'b0, key};
      endcase
   endfunction

   function automatic logic [TW-1:0] model_tab();
      logic [TW-1:0] v;
      v = '0;
      for (int r = 0; r < NQ; r++)
         for (int q = 0; q < NQ; q++) v[2*(r*NQ+q) +: 2] = enc(m_tab[r][q]);
      return v;
   endfunction

   function automatic logic [NQ-1:0] model_phase();
      logic [NQ-1:0] v;
      for (int r = 0; r < NQ; r++) v[r] = m_sign[r];
      return v;
   endfunction

   function automatic void model_apply(input gate_rec_t g);
      logic [8:0]  one;
      logic [16:0] two;
      if (g.kind == 2'd3) return;
      if (g.q1 >= NQ || (g.kind == 2'd2 && (g.q2 >= NQ || g.q1 == g.q2))) begin
         m_err = 1'b1;
         return;
      end
      for (int r = 0; r < NQ; r++) begin
         if (g.kind == 2'd2) begin
            two = cnot_inv(m_tab[r][g.q1], m_tab[r][g.q2]);
            m_tab[r][g.q1] = byte'(two[15:8]);
            m_tab[r][g.q2] = byte'(two[7:0]);
            m_sign[r] = m_sign[r] ^ two[16];
         end else begin
            one = (g.kind == 2'd0) ? h_inv(m_tab[r][g.q1]) : sdg_inv(m_tab[r][g.q1]);
            m_tab[r][g.q1] = byte'(one[7:0]);
            m_sign[r] = m_sign[r] ^ one[8];
         end
      end
   endfunction

   task automatic clearModelTab();
      for (int r = 0; r < NQ; r++) begin
         m_sign[r] = 1'b0;
         for (int q = 0; q < NQ; q++) m_tab[r][q] = "I";
      end
   endtask

   task automatic randomModelTab();
      for (int r = 0; r < NQ; r++) begin
         m_sign[r] = 1'($urandom_range(0, 1));
         for (int q = 0; q < NQ; q++) m_tab[r][q] = dec(2'($urandom_range(0, 3)));
      end
   endtask

   task automatic driveLoad();
      tableau_in = model_tab();
      phase_in   = model_phase();
      load       = 1'b1;
   endtask

   task automatic loadModel();
      driveLoad();
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clearModelTab();
      m_err = 1'b0;
      m_lifo.delete();
      sb.delete();
   endtask

   task automatic pushGate(input logic [1:0] kind, input int q1, input int q2, input bit with_load);
      bit        exp_ready;
      gate_rec_t g;
      gate_valid = 1'b1;
      gate_type  = kind;
      gate_q1    = QW'(q1);
      gate_q2    = QW'(q2);
      if (with_load) begin
         randomModelTab();
         driveLoad();
      end
      exp_ready = (m_lifo.size() < DEPTH);
      checkOutput("gate_ready_idle", gate_ready, exp_ready);
      if (exp_ready) begin
         g = '{kind: kind, q1: q1, q2: q2};
         m_lifo.push_back(g);
      end
      @(negedge clk);
      gate_valid = 1'b0;
      load       = 1'b0;
   endtask

   task automatic startReplay(input bit junk);
      int   n;
      exp_t e;
      n     = m_lifo.size();
      start = 1'b1;
      if (junk) begin
         load       = 1'b1;
         tableau_in = TW'($urandom);
         phase_in   = NQ'($urandom);
         gate_valid = 1'b1;
         gate_type  = 2'($urandom_range(0, 3));
      end
      while (m_lifo.size() > 0) model_apply(m_lifo.pop_back());
      e.tab      = model_tab();
      e.ph       = model_phase();
      e.er       = m_err;
      e.done_cyc = cyc + 1 + n;
      sb.push_back(e);
      @(negedge clk);
      start      = 1'b0;
      load       = 1'b0;
      gate_valid = 1'b0;
      if (n == 0) checkOutput("busy_empty", busy, 1'b0);
      for (int i = 0; i < n; i++) begin
         checkOutput("busy_run", busy, 1'b1);
         checkOutput("ready_run", gate_ready, 1'b0);
         load       = 1'b1;
         start      = 1'b1;
         gate_valid = 1'b1;
         tableau_in = TW'($urandom);
         @(negedge clk);
      end
      load       = 1'b0;
      start      = 1'b0;
      gate_valid = 1'b0;
   endtask

   task automatic waitDone();
      int i;
      i = 0;
      while (sb.size() != 0 && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (sb.size() != 0) begin
         checkOutput("done_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
      checkOutput("count_idle", gate_count, 0);
      checkOutput("busy_idle", busy, 1'b0);
   endtask

   task automatic applyStimulus();
      int         n;
      logic [1:0] kind;
      int         q1, q2;
      if ($urandom_range(0, 7) == 0) doReset();
      n = $urandom_range(0, DEPTH);
      if ($urandom_range(0, 1) == 1) begin
         randomModelTab();
         loadModel();
      end
      for (int i = 0; i < n; i++) begin
         kind = 2'($urandom_range(0, 3));
         q1   = ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, NQ - 1);
         q2   = ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, NQ - 1);
         pushGate(kind, q1, q2, $urandom_range(0, 3) == 0);
      end
      startReplay($urandom_range(0, 2) == 0);
      waitDone();
   endtask

   // Monitor: every done pulse consumes exactly one expected replay result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_done", done, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("done_latency", cyc, mon_e.done_cyc);
            checkOutput("tableau", tableau_out, mon_e.tab);
            checkOutput("phase", phase_out, mon_e.ph);
            checkOutput("err", err, mon_e.er);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; load = 1'b0; gate_valid = 1'b0; start = 1'b0;
      tableau_in = '0; phase_in = '0; gate_type = '0; gate_q1 = '0; gate_q2 = '0;
      doReset();

      checkOutput("rst_ready", gate_ready, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_count", gate_count, 0);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_tableau", tableau_out, 0);
      checkOutput("rst_phase", phase_out, 0);

      $display("[TB] H then S on row0=X");
      clearModelTab();
      m_tab[0][0] = "X";
      loadModel();
      pushGate(2'd0, 0, 0, 1'b0);
      pushGate(2'd1, 0, 0, 1'b0);
      startReplay(1'b0);
      waitDone();
      checkOutput("tp1_row0", tableau_out[RW-1:0], 6'b000011);
      checkOutput("tp1_phase0", phase_out[0], 1'b0);

      $display("[TB] CNOT(0,1) round trips");
      clearModelTab();
      m_tab[0][0] = "X";
      m_tab[0][1] = "Z";
      loadModel();
      pushGate(2'd2, 0, 1, 1'b0);
      startReplay(1'b0);
      waitDone();
      checkOutput("tp2_row0", tableau_out[RW-1:0], 6'b001111);
      checkOutput("tp2_phase0", phase_out[0], 1'b1);
      clearModelTab();
      m_tab[1][0] = "Y";
      m_tab[1][1] = "Y";
      loadModel();
      pushGate(2'd2, 0, 1, 1'b0);
      startReplay(1'b0);
      waitDone();
      checkOutput("tp2_row1", tableau_out[RW +: RW], 6'b000110);
      checkOutput("tp2_phase1", phase_out[1], 1'b1);

      $display("[TB] LIFO capacity");
      randomModelTab();
      loadModel();
      pushGate(2'd0, 0, 0, 1'b0);
      pushGate(2'd1, 1, 0, 1'b0);
      pushGate(2'd2, 0, 2, 1'b0);
      pushGate(2'd3, 2, 1, 1'b0);
      pushGate(2'd0, 2, 0, 1'b0);
      checkOutput("count_full", gate_count, DEPTH);
      startReplay(1'b1);
      waitDone();

      $display("[TB] empty replay with competing load and push");
      startReplay(1'b1);
      waitDone();

      $display("[TB] illegal CNOT sets err");
      pushGate(2'd2, 1, 1, 1'b0);
      pushGate(2'd0, 0, 0, 1'b0);
      clearModelTab();
      m_tab[0][0] = "Z";
      loadModel();
      startReplay(1'b0);
      waitDone();
      checkOutput("tp5_row0", tableau_out[RW-1:0], 6'b000010);
      checkOutput("tp5_err", err, 1'b1);

      $display("[TB] reset during replay");
      randomModelTab();
      loadModel();
      pushGate(2'd0, 1, 0, 1'b0);
      pushGate(2'd1, 2, 0, 1'b0);
      pushGate(2'd2, 2, 0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("mid_busy", busy, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clearModelTab();
      m_err = 1'b0;
      m_lifo.delete();
      checkOutput("mid_count", gate_count, 0);
      checkOutput("mid_ready", gate_ready, 1'b1);
      checkOutput("mid_busy_low", busy, 1'b0);
      checkOutput("mid_done", done, 1'b0);
      checkOutput("mid_tableau", tableau_out, 0);
      checkOutput("mid_phase", phase_out, 0);
      checkOutput("mid_err", err, 1'b0);
      repeat (5) @(negedge clk);

      $display("[TB] randomized replays");
      for (int round = 0; round < 40; round++) applyStimulus();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
